// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic tile driver.
package systolic_pkg;

    localparam int ARRAY_SIZE = 4;
    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 32;

    // Driver sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        CAPTURE,
        OUTPUT
    } state_t;

    // One operand vector (A column or B row), lane 0 in the low bits.
    typedef logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] a_vec_t;

    // One result row, lane 0 = column 0.
    typedef logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] c_row_t;

endpackage

// File: rtl/systolic_tile_driver.sv
// Initiator-side controller for the 4x4 signed systolic MAC array: clears the
// array, streams one tile of operand beats, flushes with zeros, captures the
// 16 accumulators and returns them as four row beats.
module systolic_tile_driver #(
    parameter int ARRAY_SIZE   = systolic_pkg::ARRAY_SIZE,
    parameter int DATA_WIDTH   = systolic_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH    = systolic_pkg::ACC_WIDTH,
    parameter int CLR_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 12,
    parameter int KCNT_WIDTH   = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    op_valid,
    output logic                                    op_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]        op_a,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]        op_b,
    input  logic                                    op_last,
    output logic                                    arr_reset,
    output logic                                    arr_enable,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]        arr_a,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]        arr_b,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] arr_c,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]         res_data,
    output logic [1:0]                              res_row,
    output logic                                    res_last,
    output logic                                    busy,
    output logic [KCNT_WIDTH-1:0]                   k_count
);

    import systolic_pkg::*;

    localparam int         ROW_W      = ARRAY_SIZE * ACC_WIDTH;
    localparam logic [7:0] CLR_LAST   = 8'(CLR_CYCLES - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [7:0]       cnt;
    logic [ROW_W-1:0] result [ARRAY_SIZE];
    logic             beat_acc;
    logic             res_hs;

    // op_ready is the only combinational output: it is just the STREAM decode.
    assign op_ready = (state == STREAM);
    assign beat_acc = op_valid && op_ready;
    assign res_hs   = (state == OUTPUT) && res_valid && res_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode; the IDLE beat only triggers the clear, it is not consumed.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (op_valid)                 next_state = CLEAR;
            CLEAR:   if (cnt == CLR_LAST)          next_state = STREAM;
            STREAM:  if (beat_acc && op_last)      next_state = DRAIN;
            DRAIN:   if (cnt == DRAIN_LAST)        next_state = CAPTURE;
            CAPTURE:                               next_state = OUTPUT;
            OUTPUT:  if (res_hs && res_row == 2'd3) next_state = IDLE;
            default:                               next_state = IDLE;
        endcase
    end

    // Shared dwell counter for CLEAR and DRAIN, restarted on every state change.
    always_ff @(posedge clk) begin
        if (reset)                    cnt <= '0;
        else if (next_state != state) cnt <= '0;
        else                          cnt <= cnt + 8'd1;
    end

    // Beats accepted in the current tile; cleared when a new tile starts, saturating.
    always_ff @(posedge clk) begin
        if (reset)                               k_count <= '0;
        else if (state == IDLE && op_valid)      k_count <= '0;
        else if (beat_acc && !(&k_count))        k_count <= k_count + KCNT_WIDTH'(1);
    end

    // Array drive. The last beat lands in the first DRAIN cycle, so enable stays
    // high for every DRAIN cycle: one data cycle followed by zero flush cycles.
    // Bubbles drop enable and hold the operands so the frozen array is unaffected.
    always_ff @(posedge clk) begin
        if (reset) begin
            arr_reset  <= 1'b1;
            arr_enable <= 1'b0;
            arr_a      <= '0;
            arr_b      <= '0;
        end else begin
            arr_reset  <= (next_state == CLEAR);
            arr_enable <= beat_acc || (state == DRAIN && next_state == DRAIN);
            if (beat_acc) begin
                arr_a <= op_a;
                arr_b <= op_b;
            end else if (state == DRAIN) begin
                arr_a <= '0;
                arr_b <= '0;
            end
        end
    end

    // Snapshot all accumulators in CAPTURE, stored row by row.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ARRAY_SIZE; r++) result[r] <= '0;
        end else if (state == CAPTURE) begin
            for (int r = 0; r < ARRAY_SIZE; r++) result[r] <= arr_c[r*ROW_W +: ROW_W];
        end
    end

    // Result beats. Row 0 is loaded straight from arr_c while the snapshot is
    // being taken; later rows come from the snapshot on each handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_row   <= 2'd0;
            res_last  <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= (next_state == OUTPUT);
            if (state == CAPTURE) begin
                res_row  <= 2'd0;
                res_last <= 1'b0;
                res_data <= arr_c[0 +: ROW_W];
            end else if (res_hs) begin
                if (res_row == 2'd3) begin
                    res_row  <= 2'd0;
                    res_last <= 1'b0;
                end else begin
                    res_row  <= res_row + 2'd1;
                    res_last <= (res_row == 2'd2);
                    res_data <= result[res_row + 2'd1];
                end
            end
        end
    end

    // Busy flag tracks the registered state one-for-one.
    always_ff @(posedge clk) begin
        if (reset) busy <= 1'b0;
        else       busy <= (next_state != IDLE);
    end

endmodule

// File: tb/tb_systolic_tile_driver.sv
// Directed bench for systolic_tile_driver with a behavioural 4x4 MAC array.
module tb_systolic_tile_driver;

    localparam int CLR   = 4;
    localparam int DRAIN = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid, op_ready, op_last;
    logic [31:0]  op_a, op_b;
    logic         arr_reset, arr_enable;
    logic [31:0]  arr_a, arr_b;
    logic [511:0] arr_c;
    logic         res_valid, res_ready, res_last, busy;
    logic [127:0] res_data;
    logic [1:0]   res_row;
    logic [15:0]  k_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_tile_driver dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_last(op_last),
        .arr_reset(arr_reset), .arr_enable(arr_enable), .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
        .res_last(res_last), .busy(busy), .k_count(k_count)
    );

    // Behavioural array: clears while arr_reset, accumulates the outer product when enabled.
    logic signed [31:0] acc [16];
    always @(posedge clk) begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (arr_reset)
                    acc[r*4+c] <= '0;
                else if (arr_enable)
                    acc[r*4+c] <= acc[r*4+c] +
                        32'($signed(arr_a[r*8 +: 8]) * $signed(arr_b[c*8 +: 8]));
    end

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < 16; i++) arr_c[i*32 +: 32] = acc[i];
    end

    typedef struct {
        int               k;
        bit               bubble;
        bit               stall;
        bit               lat;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [15:0][31:0] c;
    } tvec_t;

    tvec_t tv [7];

    function automatic logic [31:0] p4(int x0, int x1, int x2, int x3);
        return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_tile(input tvec_t v, input string tag);
        int t, t0, clr;
        t0 = 0;
        for (int j = 0; j < v.k; j++) begin
            op_valid = 1'b1;
            op_a     = v.a[j];
            op_b     = v.b[j];
            op_last  = (j == v.k - 1);
            t = 0; clr = 0;
            while (!op_ready && t < 100) begin
                @(posedge clk); #1; t++;
                if (arr_reset) clr++;
            end
            if (!op_ready) begin
                chk({tag, " op_ready timeout"}, 128'(op_ready), 128'(1));
                op_valid = 1'b0;
                return;
            end
            if (j == 0) begin
                t0 = cyc;
                chk({tag, " clear cycles"}, 128'(clr), 128'(CLR));
            end
            @(posedge clk); #1;
            op_valid = 1'b0;
            op_last  = 1'b0;
            chk({tag, " beat enable"}, 128'(arr_enable), 128'(1));
            chk({tag, " beat a/b"}, {arr_a, arr_b}, {v.a[j], v.b[j]});
            if (v.bubble && j < v.k - 1) begin
                @(posedge clk); #1;
                chk({tag, " bubble enable"}, 128'(arr_enable), 128'(0));
                chk({tag, " bubble hold"}, {arr_a, arr_b}, {v.a[j], v.b[j]});
                @(posedge clk); #1;
            end
        end
        t = 0;
        while (!res_valid && t < 200) begin @(posedge clk); #1; t++; end
        if (!res_valid) begin
            chk({tag, " res_valid timeout"}, 128'(res_valid), 128'(1));
            return;
        end
        if (v.lat) chk({tag, " latency"}, 128'(cyc - t0), 128'(v.k + DRAIN + 1));
        for (int r = 0; r < 4; r++) begin
            chk({tag, " row valid"}, 128'(res_valid), 128'(1));
            chk({tag, " row index"}, 128'(res_row), 128'(r));
            chk({tag, " row last"}, 128'(res_last), 128'(r == 3));
            chk({tag, " row data"}, res_data, v.c[r*4 +: 4]);
            if (v.stall && r == 1) begin
                repeat (5) begin
                    @(posedge clk); #1;
                    chk({tag, " stall hold"}, {res_data, 6'(res_row), res_valid, res_last},
                        {v.c[4 +: 4], 6'd1, 1'b1, 1'b0});
                end
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
        chk({tag, " end res_valid"}, 128'(res_valid), 128'(0));
        chk({tag, " end busy"}, 128'(busy), 128'(0));
        chk({tag, " k_count"}, 128'(k_count), 128'(v.k));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        int mix [16] = '{-10, 12, -14, 16, 20, -24, 28, -32, -30, 36, -42, 48, 40, -48, 56, -64};

        for (int i = 0; i < 7; i++) begin
            tv[i].k = 1; tv[i].bubble = 0; tv[i].stall = 0; tv[i].lat = 0;
            tv[i].a = '0; tv[i].b = '0; tv[i].c = '0;
        end
        // K=1, a=(1,2,3,4), b=ones: row r is all r+1
        tv[0].lat = 1; tv[0].a[0] = p4(1, 2, 3, 4); tv[0].b[0] = p4(1, 1, 1, 1);
        for (int i = 0; i < 16; i++) tv[0].c[i] = 32'(i / 4 + 1);
        // K=3, all -128: 3 * 16384
        tv[1].k = 3;
        for (int j = 0; j < 3; j++) begin tv[1].a[j] = p4(-128, -128, -128, -128); tv[1].b[j] = tv[1].a[j]; end
        for (int i = 0; i < 16; i++) tv[1].c[i] = 32'd49152;
        // K=4 identity (with bubbles, then bubble-free with a stalled row 1): C = M
        tv[2].k = 4; tv[2].bubble = 1;
        tv[3].k = 4; tv[3].stall = 1; tv[3].lat = 1;
        for (int j = 0; j < 4; j++) begin
            tv[2].a[j] = 32'(1) << (8 * j);
            tv[2].b[j] = p4(4*j, 4*j+1, 4*j+2, 4*j+3);
            tv[3].a[j] = tv[2].a[j];
            tv[3].b[j] = tv[2].b[j];
        end
        for (int i = 0; i < 16; i++) begin tv[2].c[i] = 32'(i); tv[3].c[i] = 32'(i); end
        // K=2 mixed signs, same beat twice
        tv[4].k = 2;
        for (int j = 0; j < 2; j++) begin tv[4].a[j] = p4(-1, 2, -3, 4); tv[4].b[j] = p4(5, -6, 7, -8); end
        for (int i = 0; i < 16; i++) tv[4].c[i] = 32'(mix[i]);
        // K=2 all ones, then straight into K=1 single-entry tile
        tv[5].k = 2;
        for (int j = 0; j < 2; j++) begin tv[5].a[j] = p4(1, 1, 1, 1); tv[5].b[j] = p4(1, 1, 1, 1); end
        for (int i = 0; i < 16; i++) tv[5].c[i] = 32'd2;
        tv[6].a[0] = p4(1, 0, 0, 0); tv[6].b[0] = p4(1, 0, 0, 0); tv[6].c[0] = 32'd1;

        reset = 1'b1; op_valid = 1'b0; op_last = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset arr_reset", 128'(arr_reset), 128'(1));
        chk("reset misc", {arr_enable, op_ready, res_valid, res_last, busy, 2'(res_row)}, '0);
        chk("reset data", {arr_a, arr_b, 16'(k_count)}, '0);
        chk("reset res_data", res_data, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle arr_reset", 128'(arr_reset), 128'(0));
        chk("idle busy", 128'(busy), 128'(0));

        for (int i = 0; i < 7; i++) run_tile(tv[i], $sformatf("t%0d", i));

        // Abort mid-STREAM after two beats
        op_valid = 1'b1; op_a = tv[3].a[0]; op_b = tv[3].b[0]; op_last = 1'b0;
        seen = 0;
        while (!op_ready && seen < 100) begin @(posedge clk); #1; seen++; end
        @(posedge clk); #1;
        op_a = tv[3].a[1]; op_b = tv[3].b[1];
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("abort k_count", 128'(k_count), 128'(2));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort arr_reset", 128'(arr_reset), 128'(1));
        chk("abort misc", {arr_enable, op_ready, res_valid, res_last, busy, 2'(res_row)}, '0);
        chk("abort data", {arr_a, arr_b, 16'(k_count)}, '0);
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (res_valid || busy) seen++; end
        chk("abort no stale beat", 128'(seen), 128'(0));
        run_tile(tv[0], "post-reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_tile_driver.md
Name: systolic_tile_driver

Overview:
Initiator-side controller for the 4x4 signed systolic MAC array.
- Accepts a tile of K operand beats over valid/ready. Each beat is one A column plus one B row.
- Clears the array accumulators, then streams the beats into the array's a/b ports with enable control.
- Flushes the array pipeline with zeros, captures the 16 accumulated results, and emits them as 4 row beats over valid/ready.
- Sits between the operand buffer and the array. Result: C = sum over k of a_k * b_k^T.

Parameters:
ARRAY_SIZE, 4, array dimension (fixed at 4; other values unsupported)
DATA_WIDTH, 8, signed operand width
ACC_WIDTH, 32, signed accumulator width
CLR_CYCLES, 4, cycles arr_reset is held high per tile (covers the array's 2-stage reset sync plus 2 margin)
DRAIN_CYCLES, 12, zero-operand enable cycles after the last beat before results are stable
KCNT_WIDTH, 16, width of k_count

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
op_valid  in  1  operand beat valid
op_ready  out  1  operand beat accepted when op_valid&op_ready
op_a  in  4*DATA_WIDTH  A column; lane i = [i*DW +: DW] drives row i
op_b  in  4*DATA_WIDTH  B row; lane j drives column j
op_last  in  1  final beat of tile
arr_reset  out  1  to array reset
arr_enable  out  1  to array enable
arr_a  out  4*DATA_WIDTH  to array a1..a4 (lane 0 = a1)
arr_b  out  4*DATA_WIDTH  to array b1..b4
arr_c  in  16*ACC_WIDTH  from array c1..c16; index r*4+c (c1 = lane 0)
res_valid  out  1  result row valid
res_ready  in  1  result row accepted
res_data  out  4*ACC_WIDTH  row r, lane c = C[r][c]
res_row  out  2  row index of res_data
res_last  out  1  high with row 3
busy  out  1  high in any state but IDLE
k_count  out  KCNT_WIDTH  beats accepted in current tile; saturates at all-ones

Behaviour:
- Reset values: arr_reset=1, arr_enable=0, arr_a=arr_b=0, op_ready=0, res_valid=0, res_row=0, res_last=0, res_data=0, busy=0, k_count=0, state=IDLE, captured results=0.
- Reset mid-operation: abort immediately, return to IDLE, discard in-flight operands and results. No partial res beat is emitted after reset.
- All outputs are registered except op_ready, which is decoded from state.
- IDLE: arr_reset=0 (cycle after reset release), arr_enable=0.
  - op_valid=1 -> CLEAR. The beat is not consumed.
  - k_count cleared on exit.
- CLEAR: arr_reset=1 for exactly CLR_CYCLES cycles, arr_enable=0, op_ready=0 -> STREAM.
- STREAM: op_ready=1.
  - Accepted beat: next cycle arr_a=op_a, arr_b=op_b, arr_enable=1; k_count+1.
  - Cycle with no beat (bubble): next cycle arr_enable=0 and arr_a/arr_b hold. The array freezes, so bubbles must not change the results.
  - Accepted beat with op_last=1 -> DRAIN. K=1 (op_last on first beat) is legal.
- DRAIN: op_ready=0, arr_a=arr_b=0, arr_enable=1 for exactly DRAIN_CYCLES consecutive cycles -> CAPTURE.
- CAPTURE: one cycle with arr_enable=0. Latch all 16 arr_c lanes into the internal result registers -> OUTPUT.
- OUTPUT: res_valid=1, res_row starts at 0, res_data = captured row res_row, res_last=(res_row==3).
  - Handshake advances res_row.
  - res_ready=0: res_data, res_row, res_valid held stable.
  - Handshake on row 3 -> IDLE with res_valid=0 the next cycle.
  - arr_enable=0 throughout.
- Latency for K beats with no bubbles, measured from the first accepted beat to res_valid: K + DRAIN_CYCLES + 1 cycles, plus the CLEAR prefix from IDLE.
- Arithmetic is performed by the array. The driver does no truncation: operands pass through bit-exact, results pass through as two's complement ACC_WIDTH.
- Back-to-back tiles: each tile always passes through CLEAR, so no accumulation carries over.

Decomposition:
- Shared package systolic_pkg holds:
  - ARRAY_SIZE, DATA_WIDTH, ACC_WIDTH defaults
  - the state enum: IDLE, CLEAR, STREAM, DRAIN, CAPTURE, OUTPUT
  - a_vec_t / c_row_t packed typedefs
- No sub-module. Single FSM plus a shared cycle counter (CLEAR/DRAIN), k counter, row counter and 16-entry result register.

Test Plan:
- K=1, a=(1,2,3,4), b=(1,1,1,1) -> rows: (1,1,1,1), (2,2,2,2), (3,3,3,3), (4,4,4,4); res_last only on row 3; k_count=1.
- K=3 with a=b=(-128,-128,-128,-128) per beat -> every C entry = 49152; signs correct.
- K=4 identity (beat k: a=e_k, b=row k of M, M[r][c]=r*4+c) with op_valid toggled 1,0,0,1,... -> output equals M, identical to the bubble-free run.
- res_ready held low 5 cycles on row 1 -> res_data/res_row stable; rows still delivered in order 0..3, each exactly once.
- Tile 1 all-ones (K=2, C=2) immediately followed by tile 2 K=1 a=b=(1,0,0,0) -> tile 2 C[0][0]=1, all other entries 0.
- reset asserted during STREAM after 2 beats, then a new K=1 tile -> all outputs at reset values the next cycle, no stale res beat, new tile correct.
